// File: rtl/control_multi_ws.sv
// Multicycle RV32I control FSM with memory wait-states and a ready handshake.
// Optional illegal-opcode trap is enabled by defining MULTI_TRAP_EN.
module control_multi_ws #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned STATE_W = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [6:0]         Opcode,
  input  logic               iMemReady,
  output logic               oEscreveIR,
  output logic               oEscrevePC,
  output logic               oEscrevePCCond,
  output logic               oEscrevePCBack,
  output logic [1:0]         oOrigAULA,
  output logic [1:0]         oOrigBULA,
  output logic [1:0]         oMem2Reg,
  output logic [1:0]         oALUOp,
  output logic               oOrigPC,
  output logic               oIouD,
  output logic               oRegWrite,
  output logic               oMemWrite,
  output logic               oMemRead,
  output logic               oInstrDone,
  output logic               oTrap,
  output logic [STATE_W-1:0] oState
);

  typedef enum logic [3:0] {
    StFetch, StFetchWb, StDecode, StLwSw, StLw, StLwWb, StSw, StRtype,
    StUlaRegWrite, StBranch, StJal, StOpImm, StJalr, StLui, StAuipc, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] WcntMax = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       mem_done;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StFetch;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Memory states exit only once the latency has elapsed and memory is ready.
  assign mem_done = (wcnt_q == WcntMax) && iMemReady;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (mem_done) state_d = StFetchWb;
      StFetchWb: state_d = StDecode;
      StDecode: begin
        unique case (Opcode)
          OpLoad, OpStore: state_d = StLwSw;
          OpRtype:         state_d = StRtype;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpOpImm:         state_d = StOpImm;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
`ifdef MULTI_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StLwSw: begin
        if (Opcode == OpLoad)       state_d = StLw;
        else if (Opcode == OpStore) state_d = StSw;
        else                        state_d = StFetch;
      end
      StLw:   if (mem_done) state_d = StLwWb;
      StSw:   if (mem_done) state_d = StFetch;
      StRtype, StOpImm, StLui, StAuipc: state_d = StUlaRegWrite;
`ifdef MULTI_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) begin
      wcnt_d = 4'd0;
    end else if ((state_q == StFetch || state_q == StLw || state_q == StSw) &&
                 (wcnt_q != WcntMax)) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  always_comb begin
    oEscreveIR     = 1'b0;
    oEscrevePC     = 1'b0;
    oEscrevePCCond = 1'b0;
    oEscrevePCBack = 1'b0;
    oOrigAULA      = 2'b00;
    oOrigBULA      = 2'b00;
    oMem2Reg       = 2'b00;
    oALUOp         = 2'b00;
    oOrigPC        = 1'b0;
    oIouD          = 1'b0;
    oRegWrite      = 1'b0;
    oMemWrite      = 1'b0;
    oMemRead       = 1'b0;
    oInstrDone     = 1'b0;
    oTrap          = 1'b0;
    unique case (state_q)
      StFetch: begin
        oMemRead  = 1'b1;
        oOrigAULA = 2'b10;
        oOrigBULA = 2'b01;
      end
      StFetchWb: begin
        oEscreveIR     = 1'b1;
        oEscrevePC     = 1'b1;
        oEscrevePCBack = 1'b1;
        oMemRead       = 1'b1;
        oOrigAULA      = 2'b10;
        oOrigBULA      = 2'b01;
      end
      StDecode: oOrigBULA = 2'b10;
      StLwSw: begin
        oOrigAULA  = 2'b01;
        oOrigBULA  = 2'b10;
        oInstrDone = (state_d == StFetch);
      end
      StLw: begin
        oIouD    = 1'b1;
        oMemRead = 1'b1;
      end
      StLwWb: begin
        oMem2Reg   = 2'b10;
        oRegWrite  = 1'b1;
        oInstrDone = 1'b1;
      end
      StSw: begin
        oIouD      = 1'b1;
        oMemWrite  = 1'b1;
        oInstrDone = mem_done;
      end
      StRtype: begin
        oOrigAULA = 2'b01;
        oALUOp    = 2'b10;
      end
      StOpImm: begin
        oOrigAULA = 2'b01;
        oOrigBULA = 2'b10;
        oALUOp    = 2'b10;
      end
      StLui: begin
        oOrigBULA = 2'b10;
        oALUOp    = 2'b11;
      end
      StAuipc: oOrigBULA = 2'b10;
      StUlaRegWrite: begin
        oRegWrite  = 1'b1;
        oInstrDone = 1'b1;
      end
      StBranch: begin
        oEscrevePCCond = 1'b1;
        oOrigPC        = 1'b1;
        oOrigAULA      = 2'b01;
        oALUOp         = 2'b01;
        oInstrDone     = 1'b1;
      end
      StJal: begin
        oEscrevePC = 1'b1;
        oOrigPC    = 1'b1;
        oMem2Reg   = 2'b01;
        oRegWrite  = 1'b1;
        oInstrDone = 1'b1;
      end
      StJalr: begin
        oEscrevePC = 1'b1;
        oOrigAULA  = 2'b01;
        oOrigBULA  = 2'b10;
        oMem2Reg   = 2'b01;
        oRegWrite  = 1'b1;
        oInstrDone = 1'b1;
      end
`ifdef MULTI_TRAP_EN
      StTrap: oTrap = 1'b1;
`endif
      default: ;
    endcase
  end

  assign oState = STATE_W'(state_q);

endmodule

// File: tb/tb_control_multi_ws.sv
// Scoreboard bench for control_multi_ws: three instances (MEM_LAT 1, 2, 3) driven by
// directed per-cycle vectors; a negedge monitor pops and checks expected snapshots.
module tb_control_multi_ws;

  logic       clk;
  logic       rst;
  logic [6:0] op_r  [1:3];
  logic       rdy_r [1:3];
  logic [18:0] ctrl_w [1:3];
  logic [3:0]  st_w   [1:3];

  int cycle_cnt = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [3:0]  st;
    logic [18:0] ctrl;
    string       name;
  } sb_t;
  sb_t sbq[$];

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpAddi   = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpIllegal = 7'b1111111;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    logic       eir, epc, epcc, epcb, opc, iord, rw, mw, mr, done, trp;
    logic [1:0] aa, ab, m2r, alu;
    logic [3:0] st;
    control_multi_ws #(.MEM_LAT(g), .STATE_W(4)) u_dut (
      .iCLK(clk), .iRST(rst), .Opcode(op_r[g]), .iMemReady(rdy_r[g]),
      .oEscreveIR(eir), .oEscrevePC(epc), .oEscrevePCCond(epcc), .oEscrevePCBack(epcb),
      .oOrigAULA(aa), .oOrigBULA(ab), .oMem2Reg(m2r), .oALUOp(alu),
      .oOrigPC(opc), .oIouD(iord), .oRegWrite(rw), .oMemWrite(mw), .oMemRead(mr),
      .oInstrDone(done), .oTrap(trp), .oState(st)
    );
    assign ctrl_w[g] = {eir, epc, epcc, epcb, aa, ab, m2r, alu, opc, iord, rw, mw, mr, done, trp};
    assign st_w[g]   = st;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Expected control word per state, straight from the state table.
  function automatic logic [18:0] exp_ctrl(input logic [3:0] s, input logic d);
    logic eir = 0, epc = 0, epcc = 0, epcb = 0, opc = 0, iord = 0, rw = 0, mw = 0, mr = 0;
    logic trp = 0;
    logic [1:0] aa = 2'b00, ab = 2'b00, m2r = 2'b00, alu = 2'b00;
    case (s)
      4'd0:  begin mr = 1; aa = 2'b10; ab = 2'b01; end
      4'd1:  begin eir = 1; epc = 1; epcb = 1; mr = 1; aa = 2'b10; ab = 2'b01; end
      4'd2:  begin aa = 2'b00; ab = 2'b10; end
      4'd3:  begin aa = 2'b01; ab = 2'b10; end
      4'd4:  begin iord = 1; mr = 1; end
      4'd5:  begin m2r = 2'b10; rw = 1; end
      4'd6:  begin iord = 1; mw = 1; end
      4'd7:  begin aa = 2'b01; ab = 2'b00; alu = 2'b10; end
      4'd8:  begin rw = 1; end
      4'd9:  begin epcc = 1; opc = 1; aa = 2'b01; alu = 2'b01; end
      4'd10: begin epc = 1; opc = 1; m2r = 2'b01; rw = 1; end
      4'd11: begin aa = 2'b01; ab = 2'b10; alu = 2'b10; end
      4'd12: begin epc = 1; aa = 2'b01; ab = 2'b10; m2r = 2'b01; rw = 1; end
      4'd13: begin ab = 2'b10; alu = 2'b11; end
      4'd14: begin aa = 2'b00; ab = 2'b10; alu = 2'b00; end
      default: begin trp = 1; end
    endcase
    return {eir, epc, epcc, epcb, aa, ab, m2r, alu, opc, iord, rw, mw, mr, d, trp};
  endfunction

  // Drive one cycle of inputs, queue the expected snapshot for it, advance.
  task automatic step(input int sel, input logic [6:0] op, input logic rdy, input logic r,
                      input logic [3:0] st, input logic d, input string nm);
    sb_t e;
    op_r[sel]  = op;
    rdy_r[sel] = rdy;
    rst        = r;
    e.cyc  = cycle_cnt;
    e.sel  = sel;
    e.st   = st;
    e.ctrl = exp_ctrl(st, d);
    e.name = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cycle_cnt) begin
      sb_t e;
      e = sbq.pop_front();
      n_chk++;
      if (e.cyc != cycle_cnt) begin
        n_err++;
        $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)",
                 e.name, e.cyc, cycle_cnt);
      end else begin
        if (st_w[e.sel] !== e.st) begin
          n_err++;
          $display("FAIL %s state: L%0d cyc=%0d got=%0d exp=%0d",
                   e.name, e.sel, cycle_cnt, st_w[e.sel], e.st);
        end
        n_chk++;
        if (ctrl_w[e.sel] !== e.ctrl) begin
          n_err++;
          $display("FAIL %s ctrl: L%0d cyc=%0d state=%0d got=%b exp=%b",
                   e.name, e.sel, cycle_cnt, st_w[e.sel], ctrl_w[e.sel], e.ctrl);
        end
      end
    end
  end

  logic [6:0] disp_op [6];
  logic [3:0] disp_st [6];
  logic       disp_wb [6];

  initial begin
    for (int i = 1; i <= 3; i++) begin
      op_r[i]  = 7'd0;
      rdy_r[i] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADDI, MEM_LAT=2, ready tied high.
    step(2, OpAddi, 1, 1, 0, 0, "addi_rst");
    step(2, OpAddi, 1, 0, 0, 0, "addi_f0");
    step(2, OpAddi, 1, 0, 0, 0, "addi_f1");
    step(2, OpAddi, 1, 0, 1, 0, "addi_fwb");
    step(2, OpAddi, 1, 0, 2, 0, "addi_dec");
    step(2, OpAddi, 1, 0, 11, 0, "addi_opimm");
    step(2, OpAddi, 1, 0, 8, 1, "addi_wb");
    step(2, OpAddi, 1, 0, 0, 0, "addi_next");

    // Fetch stretched by ready low after the count elapsed, MEM_LAT=2.
    step(2, OpAddi, 1, 1, 0, 0, "fstr_rst");
    step(2, OpAddi, 1, 0, 0, 0, "fstr_early");
    step(2, OpAddi, 0, 0, 0, 0, "fstr_w0");
    step(2, OpAddi, 0, 0, 0, 0, "fstr_w1");
    step(2, OpAddi, 1, 0, 0, 0, "fstr_go");
    step(2, OpAddi, 1, 0, 1, 0, "fstr_fwb");

    // LW, MEM_LAT=3, ready low for five LW cycles.
    step(3, OpLoad, 1, 1, 0, 0, "lw_rst");
    for (int i = 0; i < 3; i++) step(3, OpLoad, 1, 0, 0, 0, "lw_fetch");
    step(3, OpLoad, 1, 0, 1, 0, "lw_fwb");
    step(3, OpLoad, 1, 0, 2, 0, "lw_dec");
    step(3, OpLoad, 1, 0, 3, 0, "lw_lwsw");
    for (int i = 0; i < 5; i++) step(3, OpLoad, 0, 0, 4, 0, "lw_wait");
    step(3, OpLoad, 1, 0, 4, 0, "lw_exit");
    step(3, OpLoad, 1, 0, 5, 1, "lw_wb");
    step(3, OpLoad, 1, 0, 0, 0, "lw_next");

    // SW, MEM_LAT=1, ready low for two SW cycles.
    step(1, OpStore, 1, 1, 0, 0, "sw_rst");
    step(1, OpStore, 1, 0, 0, 0, "sw_fetch");
    step(1, OpStore, 1, 0, 1, 0, "sw_fwb");
    step(1, OpStore, 1, 0, 2, 0, "sw_dec");
    step(1, OpStore, 1, 0, 3, 0, "sw_lwsw");
    step(1, OpStore, 0, 0, 6, 0, "sw_w0");
    step(1, OpStore, 0, 0, 6, 0, "sw_w1");
    step(1, OpStore, 1, 0, 6, 1, "sw_exit");
    step(1, OpStore, 1, 0, 0, 0, "sw_next");

    // AUIPC, MEM_LAT=2.
    step(2, OpAuipc, 1, 1, 0, 0, "auipc_rst");
    step(2, OpAuipc, 1, 0, 0, 0, "auipc_f0");
    step(2, OpAuipc, 1, 0, 0, 0, "auipc_f1");
    step(2, OpAuipc, 1, 0, 1, 0, "auipc_fwb");
    step(2, OpAuipc, 1, 0, 2, 0, "auipc_dec");
    step(2, OpAuipc, 1, 0, 14, 0, "auipc_st");
    step(2, OpAuipc, 1, 0, 8, 1, "auipc_wb");

    // Remaining dispatch targets, MEM_LAT=1.
    disp_op = '{7'b0110011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010011};
    disp_st = '{4'd7, 4'd9, 4'd10, 4'd12, 4'd13, 4'd11};
    disp_wb = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(1, disp_op[i], 1, 1, 0, 0, "disp_rst");
      step(1, disp_op[i], 1, 0, 0, 0, "disp_fetch");
      step(1, disp_op[i], 1, 0, 1, 0, "disp_fwb");
      step(1, disp_op[i], 1, 0, 2, 0, "disp_dec");
      if (disp_wb[i]) begin
        step(1, disp_op[i], 1, 0, disp_st[i], 0, "disp_exec");
        step(1, disp_op[i], 1, 0, 8, 1, "disp_wb");
      end else begin
        step(1, disp_op[i], 1, 0, disp_st[i], 1, "disp_exec");
      end
      step(1, disp_op[i], 1, 0, 0, 0, "disp_next");
    end

    // Opcode changes while in LWSW: falls through to FETCH.
    step(1, OpLoad, 1, 1, 0, 0, "lwsw_rst");
    step(1, OpLoad, 1, 0, 0, 0, "lwsw_fetch");
    step(1, OpLoad, 1, 0, 1, 0, "lwsw_fwb");
    step(1, OpLoad, 1, 0, 2, 0, "lwsw_dec");
    step(1, OpRtype, 1, 0, 3, 1, "lwsw_chg");
    step(1, OpRtype, 1, 0, 0, 0, "lwsw_next");

    // Illegal opcode.
    step(2, OpIllegal, 1, 1, 0, 0, "ill_rst");
    step(2, OpIllegal, 1, 0, 0, 0, "ill_f0");
    step(2, OpIllegal, 1, 0, 0, 0, "ill_f1");
    step(2, OpIllegal, 1, 0, 1, 0, "ill_fwb");
    step(2, OpIllegal, 1, 0, 2, 0, "ill_dec");
`ifdef MULTI_TRAP_EN
    for (int i = 0; i < 10; i++) step(2, OpIllegal, 1, 0, 15, 0, "ill_trap");
    step(2, OpAddi, 1, 1, 0, 0, "ill_trap_rst");
    step(2, OpAddi, 1, 0, 0, 0, "ill_after");
`else
    step(2, OpIllegal, 1, 0, 0, 0, "ill_skip0");
    step(2, OpIllegal, 1, 0, 0, 0, "ill_skip1");
    step(2, OpIllegal, 1, 0, 1, 0, "ill_fwb2");
`endif

    // Reset asserted in the second SW wait cycle, MEM_LAT=3, then a clean ADDI.
    step(3, OpStore, 1, 1, 0, 0, "swab_rst");
    for (int i = 0; i < 3; i++) step(3, OpStore, 1, 0, 0, 0, "swab_fetch");
    step(3, OpStore, 1, 0, 1, 0, "swab_fwb");
    step(3, OpStore, 1, 0, 2, 0, "swab_dec");
    step(3, OpStore, 1, 0, 3, 0, "swab_lwsw");
    step(3, OpStore, 0, 0, 6, 0, "swab_w0");
    step(3, OpAddi, 0, 1, 0, 0, "swab_abort");
    for (int i = 0; i < 3; i++) step(3, OpAddi, 1, 0, 0, 0, "swab_refetch");
    step(3, OpAddi, 1, 0, 1, 0, "swab_fwb2");
    step(3, OpAddi, 1, 0, 2, 0, "swab_dec2");
    step(3, OpAddi, 1, 0, 11, 0, "swab_opimm");
    step(3, OpAddi, 1, 0, 8, 1, "swab_wb");
    step(3, OpAddi, 1, 0, 0, 0, "swab_next");

    @(negedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/control_multi_ws.md
Name: control_multi_ws

Overview:
- Next-generation multicycle RV32I control FSM with parametrised memory wait-states and a memory-ready handshake.
- Adds AUIPC support, a per-instruction retire pulse, and an optional illegal-opcode trap.
- Sits between the instruction register opcode field and the multicycle datapath muxes/enables.
- Memory-access states stretch until the latency count is met and memory reports ready.

Parameters:
- MEM_LAT, 2, minimum cycles a memory-access state is held (legal range 1..15).
- STATE_W, 4, width of oState (≥4); the state code is zero-extended.

Ports:
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- Opcode  in  7  IR[6:0]
- iMemReady  in  1  memory ready/done for the current access
- oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack  out  1 each  register write enables
- oOrigAULA, oOrigBULA, oMem2Reg, oALUOp  out  2 each  mux selects / ALU op class
- oOrigPC, oIouD, oRegWrite, oMemWrite, oMemRead  out  1 each
- oInstrDone  out  1  one-cycle pulse on the final cycle of each instruction
- oTrap  out  1  illegal-opcode trap flag (see Optional Feature)
- oState  out  STATE_W  current state code

Behaviour:
- Registers: pr_state, plus wait counter wcnt (4 bits). Async reset → pr_state=FETCH, wcnt=0.
- All outputs are a combinational decode of pr_state (and wcnt/iMemReady for oInstrDone); no output registers.
- During and immediately after reset, outputs are the FETCH values: MemRead=1, OrigAULA=10, OrigBULA=01, all else 0.
- State codes:
  - FETCH=0, FETCH_WB=1, DECODE=2, LWSW=3, LW=4, LW_WB=5, SW=6, RTYPE=7
  - ULAREGWRITE=8, BRANCH=9, JAL=10, OPIMM=11, JALR=12, LUI=13, AUIPC=14, TRAP=15
- Wait rule for FETCH, LW, SW (the memory states):
  - wcnt increments each cycle while in the state, saturating at MEM_LAT-1.
  - The state exits only on the cycle where wcnt==MEM_LAT-1 AND iMemReady=1.
  - wcnt clears to 0 on any state change.
  - iMemReady=1 before the count elapses is ignored. iMemReady tied to 1 gives exactly MEM_LAT cycles.
- FETCH: MemRead=1, IouD=0, OrigAULA=10, OrigBULA=01, ALUOp=00 → FETCH_WB.
- FETCH_WB (1 cycle): EscreveIR=1, EscrevePC=1, EscrevePCBack=1, MemRead=1, OrigAULA=10, OrigBULA=01 → DECODE.
- DECODE: OrigAULA=00, OrigBULA=10 (branch target precompute). Dispatch:
  - LOAD 0000011 / STORE 0100011 → LWSW
  - 0110011 → RTYPE; 1100011 → BRANCH; 1101111 → JAL
  - 0010011 → OPIMM; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC
  - other → FETCH, or TRAP when the trap feature is enabled.
- LWSW: OrigAULA=01, OrigBULA=10. Goes → LW or SW; a changed opcode falls through to FETCH.
- LW: IouD=1, MemRead=1, wait rule → LW_WB.
- LW_WB: Mem2Reg=10, RegWrite=1 → FETCH.
- SW: IouD=1, MemWrite=1 held through the whole wait → FETCH.
- RTYPE: OrigAULA=01, OrigBULA=00, ALUOp=10 → ULAREGWRITE.
- OPIMM: OrigAULA=01, OrigBULA=10, ALUOp=10 → ULAREGWRITE.
- LUI: OrigBULA=10, ALUOp=11 → ULAREGWRITE.
- AUIPC: OrigAULA=00 (old PC), OrigBULA=10, ALUOp=00 → ULAREGWRITE.
- ULAREGWRITE: RegWrite=1 → FETCH.
- BRANCH: EscrevePCCond=1, OrigPC=1, OrigAULA=01, ALUOp=01 → FETCH.
- JAL: EscrevePC=1, OrigPC=1, Mem2Reg=01, RegWrite=1 → FETCH.
- JALR: EscrevePC=1, OrigAULA=01, OrigBULA=10, Mem2Reg=01, RegWrite=1 → FETCH.
- oInstrDone=1 on the cycle whose next state is FETCH, except from DECODE on an illegal opcode. For SW it asserts only on the exit cycle.
- Unencoded state values decode to all outputs 0 and next state FETCH.
- Reset asserted mid-wait aborts the access: MemWrite drops immediately and the FSM returns to FETCH.

Optional Feature:
- Macro: MULTI_TRAP_EN.
- Defined: an illegal opcode in DECODE → TRAP. TRAP drives all enables 0, oTrap=1, and holds until iRST.
- Undefined: an illegal opcode → FETCH (silently skipped), TRAP is unreachable, and oTrap is tied 0.

Test Plan:
- MEM_LAT=2, iMemReady=1, ADDI (0010011) → state sequence 0,0,1,2,11,8; oInstrDone high only in state 8; 6 cycles total.
- MEM_LAT=3, LW with iMemReady low for 5 cycles in LW → LW lasts 6 cycles with MemRead=1 and IouD=1 throughout; LW_WB asserts RegWrite=1, Mem2Reg=10.
- SW, MEM_LAT=1, iMemReady low for 2 cycles → MemWrite=1 for exactly 3 cycles; oInstrDone only on the third.
- AUIPC (0010111) → DECODE→AUIPC(14)→ULAREGWRITE; in state 14 OrigAULA=00, OrigBULA=10, ALUOp=00.
- Opcode 1111111: with MULTI_TRAP_EN → state 15, oTrap=1 held 10 cycles, iRST pulse → state 0. Without the macro → back to FETCH, oTrap=0, no oInstrDone.
- iRST asserted asynchronously in the second SW wait cycle → oState=0 and MemWrite=0 before the next clock edge; the following fetch proceeds normally.
